// File: rtl/mul_div_unit_pkg.sv
// Shared operation encodings and helpers for the execute-stage multiply/divide unit.
// The mt* values must stay in step with the controller's mulCtrl encoding.
package mul_div_unit_pkg;

    typedef enum logic [3:0] {
        MT_DISABLED  = 4'd0,
        MT_MULT      = 4'd1,
        MT_MULTU     = 4'd2,
        MT_DIV       = 4'd3,
        MT_DIVU      = 4'd4,
        MT_SET_HI    = 4'd5,
        MT_SET_LO    = 4'd6,
        MT_MADD      = 4'd7,
        MT_MADDU     = 4'd8,
        MT_MSUB      = 4'd9
    } mt_op_e;

    function automatic logic is_mul_op(input mt_op_e op);
        return (op == MT_MULT) || (op == MT_MULTU) || (op == MT_MADD) ||
               (op == MT_MADDU) || (op == MT_MSUB);
    endfunction

    function automatic logic is_div_op(input mt_op_e op);
        return (op == MT_DIV) || (op == MT_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_core.sv
// Combinational datapath: produces the 64-bit {HI,LO} result of a multiply,
// multiply-accumulate or divide from the operands and the current HI/LO.
import mul_div_unit_pkg::*;

module mul_div_core (
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0] acc;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic        b_zero;

    assign acc    = {hi, lo};
    // The low 64 bits of a sign-extended product equal the signed product mod 2^64.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign b_zero = (b == 32'd0);

    // Signed divide through magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000, rem 0.
    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;
    assign mag_q = b_zero ? 32'd0 : abs_a / abs_b;
    assign mag_r = b_zero ? 32'd0 : abs_a % abs_b;
    assign quo_s = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
    assign rem_s = a[31] ? (~mag_r + 32'd1) : mag_r;
    assign quo_u = b_zero ? 32'd0 : a / b;
    assign rem_u = b_zero ? 32'd0 : a % b;

    always_comb begin
        result = acc;
        case (mt_op_e'(ctrl))
            MT_MULT:  result = prod_s;
            MT_MULTU: result = prod_u;
            MT_MADD:  result = acc + prod_s;
            MT_MADDU: result = acc + prod_u;
            MT_MSUB:  result = acc - prod_s;
            MT_DIV:   result = b_zero ? acc : {rem_s, quo_s};
            MT_DIVU:  result = b_zero ? acc : {rem_u, quo_u};
            default:  result = acc;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, stages multi-cycle results in
// pHI/pLO and commits them when the busy counter runs out.
import mul_div_unit_pkg::*;

module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ctrl,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        outputSel,
    output logic [31:0] out,
    output logic        busy
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      p_hi;
    logic [31:0]      p_lo;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      result;
    logic             accept;
    mt_op_e           op;

    assign op     = mt_op_e'(ctrl);
    assign busy   = (cnt != '0);
    assign accept = (op != MT_DISABLED) && !busy && !cancel;
    assign out    = outputSel ? hi : lo;

    mul_div_core u_core (
        .ctrl   (ctrl),
        .a      (A),
        .b      (B),
        .hi     (hi),
        .lo     (lo),
        .result (result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            p_hi <= '0;
            p_lo <= '0;
            cnt  <= '0;
        end else if (accept) begin
            case (op)
                MT_SET_HI: hi <= A;
                MT_SET_LO: lo <= A;
                default: begin
                    // Unused encodings are accepted but change nothing.
                    if (is_mul_op(op)) begin
                        {p_hi, p_lo} <= result;
                        cnt          <= CNT_W'(MUL_CYCLES);
                    end else if (is_div_op(op)) begin
                        {p_hi, p_lo} <= result;
                        cnt          <= CNT_W'(DIV_CYCLES);
                    end
                end
            endcase
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                hi <= p_hi;
                lo <= p_lo;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: busy durations, HI/LO results, ignored
// requests, cancel and asynchronous reset in mid-operation.
import mul_div_unit_pkg::*;

module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  ctrl;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        output_sel;
    logic [31:0] out_v;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl      (ctrl),
        .cancel    (cancel),
        .A         (a),
        .B         (b),
        .outputSel (output_sel),
        .out       (out_v),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        output_sel = 1'b1;
        #1 h = out_v;
        output_sel = 1'b0;
        #1 l = out_v;
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] h;
        logic [31:0] l;
        read_hilo(h, l);
        check({tag, "_hi"}, h, eh);
        check({tag, "_lo"}, l, el);
    endtask

    // Presents a request for one accepting edge; returns just after that edge.
    task automatic issue(input mt_op_e op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        ctrl = op;
        a    = av;
        b    = bv;
        @(posedge clk);
        #1 ctrl = MT_DISABLED;
    endtask

    // Counts busy cycles sampled on falling edges; leaves us in the first idle cycle.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input mt_op_e op, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_cycles);
        int n;
        issue(op, av, bv);
        count_busy(n);
        check({tag, "_busy_cycles"}, n, exp_cycles);
    endtask

    initial begin
        int n;
        logic [31:0] h;
        logic [31:0] l;

        reset      = 1'b1;
        ctrl       = MT_DISABLED;
        cancel     = 1'b0;
        a          = '0;
        b          = '0;
        output_sel = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", busy, 1'b0);
        check_hilo("reset", 32'h0, 32'h0);

        run_op("mult", MT_MULT, 32'hFFFF_FFFF, 32'd2, 5);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        run_op("multu", MT_MULTU, 32'hFFFF_FFFF, 32'd2, 5);
        check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        run_op("div", MT_DIV, 32'hFFFF_FFF9, 32'd2, 10);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(MT_SET_HI, 32'h0000_00AA, 32'h0);
        issue(MT_SET_LO, 32'h0000_00BB, 32'h0);
        run_op("divu_zero", MT_DIVU, 32'd7, 32'd0, 10);
        check_hilo("divu_zero", 32'h0000_00AA, 32'h0000_00BB);

        issue(MT_SET_HI, 32'h1234_5678, 32'h0);
        output_sel = 1'b1;
        @(negedge clk);
        check("mthi_out", out_v, 32'h1234_5678);
        check("mthi_busy", busy, 1'b0);

        // MTLO presented while a MULT is in flight must be dropped.
        issue(MT_MULT, 32'd3, 32'd4);
        @(negedge clk);
        check("mtlo_win_busy", busy, 1'b1);
        ctrl = MT_SET_LO;
        a    = 32'h0000_DEAD;
        @(posedge clk);
        #1 ctrl = MT_DISABLED;
        count_busy(n);
        check("mtlo_win_remaining", n, 4);
        check_hilo("mtlo_ignored", 32'h0, 32'd12);

        issue(MT_SET_HI, 32'h0, 32'h0);
        issue(MT_SET_LO, 32'hFFFF_FFFF, 32'h0);
        run_op("madd", MT_MADD, 32'd1, 32'd1, 5);
        check_hilo("madd", 32'h1, 32'h0);
        run_op("msub", MT_MSUB, 32'd1, 32'd1, 5);
        check_hilo("msub", 32'h0, 32'hFFFF_FFFF);
        issue(MT_SET_LO, 32'h0, 32'h0);
        run_op("maddu", MT_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        check_hilo("maddu", 32'hFFFF_FFFE, 32'h1);

        @(negedge clk);
        cancel = 1'b1;
        ctrl   = MT_MULT;
        a      = 32'd5;
        b      = 32'd5;
        @(posedge clk);
        #1;
        ctrl   = MT_DISABLED;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy_next", busy, 1'b0);
        repeat (6) @(negedge clk);
        check("cancel_busy_later", busy, 1'b0);
        check_hilo("cancel", 32'hFFFF_FFFE, 32'h1);

        run_op("div_ovf", MT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check_hilo("div_ovf", 32'h0, 32'h8000_0000);

        run_op("divu", MT_DIVU, 32'd100, 32'd7, 10);
        check_hilo("divu", 32'd2, 32'd14);

        // Reset asserted in cycle 3 of a MULT.
        issue(MT_MULT, 32'd3, 32'd5);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check_hilo("rst_mid", 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_after_busy", busy, 1'b0);
        check_hilo("rst_after", 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Execute-stage multiply/divide unit that consumes the controller's `mulCtrl`/`mulOutputSel` control and owns the architectural HI/LO registers. It runs multi-cycle MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB operations, handles single-cycle MTHI/MTLO writes, and returns HI or LO for MFHI/MFLO. It sits beside the ALU in stage E. The hazard unit stalls on its `busy` output.

## Interface
Parameters:
- `MUL_CYCLES`, default 5: busy duration for MULT/MULTU/MADD/MADDU/MSUB (≥1).
- `DIV_CYCLES`, default 10: busy duration for DIV/DIVU (≥1).

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ctrl`  in  4  operation select (`mt*` encoding); `mtDisabled` = idle.
- `cancel`  in  1  instruction in E is being flushed; suppresses acceptance this cycle.
- `A`  in  32  rs operand, forwarded value.
- `B`  in  32  rt operand, forwarded value.
- `outputSel`  in  1  1 = HI, 0 = LO.
- `out`  out  32  selected HI/LO value, combinational from registers.
- `busy`  out  1  registered; high while a multi-cycle op is pending.

## Operation
- Accept condition: `ctrl != mtDisabled && !busy && !cancel`. Any `ctrl` while busy or cancelled is ignored entirely, including MTHI/MTLO.
- MTHI: HI <= A at the accepting edge. MTLO: LO <= A. Neither asserts busy.
- Multi-cycle ops: the accepting edge captures the result into pending registers `pHI`/`pLO` and loads the counter with N (MUL_CYCLES or DIV_CYCLES). The counter decrements each edge. On the edge where it goes 1→0, HI <= pHI and LO <= pLO.
- `busy = (counter != 0)`.
- Arithmetic, computed from A, B, HI and LO at acceptance:
  - MULT: {HI,LO} = signed 64-bit A×B.
  - MULTU: {HI,LO} = unsigned A×B.
  - MADD: {HI,LO} + signed A×B, mod 2^64.
  - MADDU: same as MADD with unsigned product.
  - MSUB: {HI,LO} − signed A×B, mod 2^64.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B = 0): still busy for DIV_CYCLES; pHI/pLO latch the current HI/LO, so HI/LO end up unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `out = outputSel ? HI : LO` at all times. During busy it shows the old values; the hazard unit must stall MFHI/MFLO.
- The hazard unit must also stall on `mulEnable` in D while `busy`. This block does not stall itself.
- Reset (async, any time, including mid-operation): HI = LO = pHI = pLO = 0, counter = 0, `busy` = 0. No commit after reset deasserts.

## Timing
- Accepting edge = edge 0. `busy` is high in cycles 1..N and low in cycle N+1.
- HI/LO hold the new values from the edge ending cycle N, so `out` is valid in cycle N+1.
- MTHI/MTLO: `out` reflects the new value in the cycle after the accepting edge.
- Back-to-back: a new op is accepted in cycle N+1 at the earliest, since `ctrl` is ignored while busy.

## Structure
- The `mt*` encodings live in `constants.v` alongside the other shared defines: mtDisabled=0, mtMultiply=1, mtMultiplyUnsigned=2, mtDivide=3, mtDivideUnsigned=4, mtSetHI=5, mtSetLO=6, mtMADD=7, mtMADDU=8, mtMSUB=9.
- One combinational sub-module, `mul_div_core`, computes the 64-bit {HI,LO} result from ctrl, A, B, HI and LO, including the divide-by-zero and overflow cases.
- The top level holds HI, LO, pHI, pLO, the counter and the accept logic.

## Test plan
- MULT A=0xFFFFFFFF, B=2 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 with HI=0xAA, LO=0xBB → 10 busy cycles; HI/LO stay 0xAA/0xBB.
- MTHI A=0x12345678, outputSel=1 → `out`=0x12345678 next cycle, `busy` never asserted. MTLO issued during a MULT's busy window → ignored; LO equals the MULT result.
- HI=0, LO=0xFFFFFFFF, MADD A=1, B=1 → HI=1, LO=0. Then MSUB A=1, B=1 → HI=0, LO=0xFFFFFFFF. MADDU A=B=0xFFFFFFFF from HI=LO=0 → HI=0xFFFFFFFE, LO=1.
- MULT with `cancel`=1 in the issue cycle → `busy` stays 0 and HI/LO are unchanged.
- Reset pulsed in cycle 3 of a MULT → `busy`=0 and HI=LO=0 immediately; no update occurs after reset is released.
